// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types, limits and configuration checks for stream_demux
// Contents: slot_state_e (EMPTY/FULL), DEMUX_MAX_CH, clog2(), cfg_ok()
package stream_demux_pkg;

    localparam int DEMUX_MAX_CH = 64;

    typedef enum logic {EMPTY, FULL} slot_state_e;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit cfg_ok(input int num_ch, input int sel_w, input int cnt_w);
        return num_ch >= 2 && num_ch <= DEMUX_MAX_CH && sel_w >= clog2(num_ch) && cnt_w >= 1;
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: producer-side and consumer-side stream signals of the demux
// Ports (signals): in_valid/in_ready/in_data/in_sel (producer), out_valid/out_ready/out_data (NUM_CH consumers)
// Modports: slave = the demux itself, master = the environment driving it
interface stream_demux_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic [SEL_W-1:0]         in_sel;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_demux_slot.sv
// demux_slot: one-beat holding register with an EMPTY/FULL state machine
// Ports: clk, rst (sync, active-high), load/load_data (write a beat),
//        out_valid/out_ready/out_data (consumer handshake)
module demux_slot import stream_demux_pkg::*; #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A load always wins: it either fills an empty slot or replaces a beat draining this cycle.
    always_comb begin
        state_d = load ? FULL : (out_ready ? EMPTY : state_q);
        data_d  = load ? load_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = state_q == FULL;
    assign out_data  = data_q;
endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NUM_CH valid/ready stream demultiplexer
// Ports: clk, rst (sync, active-high), bus (stream_demux_if.slave),
//        sel_err (one-cycle pulse after an out-of-range beat is dropped),
//        ch_count (per-channel drained-beat counters, only with STREAM_DEMUX_CNT_EN)
// Build option: define STREAM_DEMUX_CNT_EN to add the ch_count counters.
module stream_demux import stream_demux_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    stream_demux_if.slave            bus,
    output logic                     sel_err
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]  ch_count
`endif
);
    if (!cfg_ok(NUM_CH, SEL_W, CNT_W)) begin : g_bad_cfg
        $fatal(1, "stream_demux: invalid NUM_CH/SEL_W/CNT_W combination");
    end

    logic [NUM_CH-1:0]        hit, load, valid_w;
    logic [NUM_CH*DATA_W-1:0] data_w;
    logic                     in_range, in_ready, fire;
    logic                     sel_err_q, sel_err_d;

    // One-hot decode of in_sel; no hit means out-of-range, which is always accepted and dropped.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) hit[k] = 32'(bus.in_sel) == k;
        in_range  = |hit;
        in_ready  = !(|(hit & valid_w & ~bus.out_ready));
        fire      = bus.in_valid & in_ready;
        load      = hit & {NUM_CH{fire}};
        sel_err_d = fire & !in_range;
    end

    always_ff @(posedge clk) begin
        if (rst) sel_err_q <= 1'b0;
        else     sel_err_q <= sel_err_d;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[k]),
            .load_data(bus.in_data),
            .out_valid(valid_w[k]),
            .out_ready(bus.out_ready[k]),
            .out_data (data_w[k*DATA_W +: DATA_W])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_w;
    assign bus.out_data  = data_w;
    assign sel_err       = sel_err_q;

`ifdef STREAM_DEMUX_CNT_EN
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) cnt_d[k] = cnt_q[k] + CNT_W'(valid_w[k] & bus.out_ready[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign ch_count = cnt_q;
`endif
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: scoreboard bench for stream_demux (NUM_CH=3 so in_sel=3 is out of range)
module tb_stream_demux;
    localparam int DW  = 8;
    localparam int NCH = 3;
    localparam int SW  = 2;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel_err;
`ifdef STREAM_DEMUX_CNT_EN
    logic [NCH*CW-1:0] ch_count;
`endif

    stream_demux_if #(.DATA_W(DW), .NUM_CH(NCH), .SEL_W(SW)) bus ();

    stream_demux #(.DATA_W(DW), .NUM_CH(NCH), .SEL_W(SW), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .sel_err(sel_err)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .ch_count(ch_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 0;
    bit rnd = 0;

    // Reference model: each channel is a queue of beats the consumer still has to see.
    logic [DW-1:0] exp_q[NCH][$];
    bit            held[NCH];
    bit            err_exp;
    int            cnt[NCH];

    function automatic bit exp_ready();
        int s;
        s = int'(bus.in_sel);
        return (s >= NCH) ? 1'b1 : (!held[s] || bus.out_ready[s]);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            err_exp = 0;
            for (int k = 0; k < NCH; k++) begin
                held[k] = 0;
                cnt[k]  = 0;
                exp_q[k].delete();
            end
        end else begin
            bit f;
            int s;
            s = int'(bus.in_sel);
            f = bus.in_valid && exp_ready();
            for (int k = 0; k < NCH; k++) begin
                if (held[k] && bus.out_ready[k]) begin
                    held[k] = 0;
                    cnt[k]  = (cnt[k] + 1) % (1 << CW);
                end
            end
            if (f && s < NCH) begin
                held[s] = 1;
                exp_q[s].push_back(bus.in_data);
            end
            err_exp = f && s >= NCH;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (!$isunknown(bus.in_sel)) chk("in_ready", longint'(bus.in_ready), longint'(exp_ready()));
            chk("sel_err", longint'(sel_err), longint'(err_exp));
            for (int k = 0; k < NCH; k++) begin
                chk($sformatf("out_valid[%0d]", k), longint'(bus.out_valid[k]), longint'(held[k]));
                if (!rst && bus.out_valid[k] && bus.out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL data[%0d]: got beat %0h expected none", k, bus.out_data[k*DW +: DW]);
                    end else begin
                        chk($sformatf("data[%0d]", k), longint'(bus.out_data[k*DW +: DW]), longint'(exp_q[k].pop_front()));
                    end
                end
`ifdef STREAM_DEMUX_CNT_EN
                chk($sformatf("ch_count[%0d]", k), longint'(ch_count[k*CW +: CW]), longint'(cnt[k]));
`endif
            end
        end
    end

    always @(posedge clk) begin
        if (rnd) begin
            #1 bus.out_ready = NCH'($urandom);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [DW-1:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_sel   = SW'(s);
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat %0h to ch %0d got no in_ready expected 1", d, s);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.out_ready = '1;
        idle(2);
        rst = 1'b0;
        // sequential routing, consumers always ready
        for (int k = 0; k < NCH; k++) send(k, 8'hA0 + 8'(k));
        idle(2);
        // back-pressure on channel 2: second beat waits, then drain-and-refill in one cycle
        bus.out_ready = 3'b011;
        send(2, 8'h11);
        fork
            send(2, 8'h22);
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready[2] = 1'b1;
            end
        join
        idle(2);
        // channel 1 stalled does not block channel 2
        bus.out_ready = 3'b000;
        send(1, 8'h33);
        send(2, 8'h55);
        idle(2);
        bus.out_ready = '1;
        idle(2);
        // out-of-range beats are accepted and dropped
        send(3, 8'h77);
        idle(1);
        send(3, 8'h78);
        send(3, 8'h79);
        idle(2);
        // unknown select while idle
        bus.in_sel = 'x;
        idle(2);
        bus.in_sel = '0;
        // reset while channels hold beats and a beat is offered
        bus.out_ready = '0;
        send(0, 8'h90);
        send(2, 8'h92);
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd1;
        bus.in_data  = 8'h91;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = '1;
        idle(2);
        // 17 drains on channel 0 wrap a 4-bit counter to 1
        repeat (17) send(0, 8'($urandom));
        idle(2);
`ifdef STREAM_DEMUX_CNT_EN
        chk("ch_count0_wrap", longint'(ch_count[CW-1:0]), 1);
`endif
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        // random traffic with random consumer readiness
        rnd = 1;
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send($urandom_range(0, 3), 8'($urandom));
        end
        rnd = 0;
        idle(1);
        bus.out_ready = '1;
        idle(4);
        for (int k = 0; k < NCH; k++) chk($sformatf("leftover[%0d]", k), longint'(exp_q[k].size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
